// File: rtl/tbird_pkg.sv
// Shared types and constants for the Thunderbird turn scheduler.
// TBIRD_BRAKE_EN adds a fourth synchronized switch (brake).
package tbird_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    localparam logic [1:0] PH_OFF = 2'd0;
    localparam logic [1:0] PH_A   = 2'd1;
    localparam logic [1:0] PH_AB  = 2'd2;
    localparam logic [1:0] PH_ABC = 2'd3;

`ifdef TBIRD_BRAKE_EN
    localparam int NUM_SW = 4;
`else
    localparam int NUM_SW = 3;
`endif

    // Hazard wins, and both sides together also mean hazard.
    function automatic mode_t pick_mode(input logic l, input logic r, input logic h);
        if (h || (l && r))
            return MODE_HAZARD;
        else if (l)
            return MODE_LEFT;
        else
            return MODE_RIGHT;
    endfunction

endpackage

// File: rtl/tbird_sync.sv
// Multi-bit, multi-stage synchronizer for asynchronous switch inputs.
module tbird_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++)
                stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/tbird_turn_scheduler.sv
// Turn-request scheduler: synchronizes switches, latches presses, grants one mode per 4-step sequence.
// Optional brake steady-burn outputs are enabled with TBIRD_BRAKE_EN.
module tbird_turn_scheduler
    import tbird_pkg::*;
#(
    parameter int TICK_DIV    = 12500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
`ifdef TBIRD_BRAKE_EN
    input  logic       brake_sw,
    output logic       l_steady,
    output logic       r_steady,
`endif
    output logic       step_o,
    output logic       left_req,
    output logic       right_req,
    output logic [1:0] mode_o,
    output logic [1:0] phase_o,
    output logic       busy_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [NUM_SW-1:0] sw_raw, sw_s;
    logic l_s, r_s, h_s;
    logic [CW-1:0] cnt;
    logic tick;
    logic pend_l, pend_r, pend_h;
    logic l_eff, r_eff, h_eff;
    mode_t mode, mode_next;
    logic [1:0] phase, phase_next;
    logic grant, left_req_next, right_req_next;

`ifdef TBIRD_BRAKE_EN
    logic b_s;
    assign sw_raw = {brake_sw, hazard_sw, right_sw, left_sw};
    assign b_s    = sw_s[3];
`else
    assign sw_raw = {hazard_sw, right_sw, left_sw};
`endif

    tbird_sync #(.WIDTH(NUM_SW), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_s)
    );

    assign l_s   = sw_s[0];
    assign r_s   = sw_s[1];
    assign h_s   = sw_s[2];
    assign tick  = (cnt == CNT_MAX);
    assign l_eff = pend_l | l_s;
    assign r_eff = pend_r | r_s;
    assign h_eff = pend_h | h_s;

    // Sequencing only advances on tick; a sequence always returns through one idle step.
    always_comb begin
        mode_next  = mode;
        phase_next = phase;
        grant      = 1'b0;
        if (tick) begin
            if (mode == MODE_IDLE) begin
                if (l_eff || r_eff || h_eff) begin
                    grant      = 1'b1;
                    mode_next  = pick_mode(l_eff, r_eff, h_eff);
                    phase_next = PH_A;
                end else begin
                    phase_next = PH_OFF;
                end
            end else if (phase == PH_ABC) begin
                mode_next  = MODE_IDLE;
                phase_next = PH_OFF;
            end else begin
                phase_next = phase + 2'd1;
            end
        end
        left_req_next  = (mode_next == MODE_LEFT)  || (mode_next == MODE_HAZARD);
        right_req_next = (mode_next == MODE_RIGHT) || (mode_next == MODE_HAZARD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            step_o    <= 1'b0;
            mode      <= MODE_IDLE;
            phase     <= PH_OFF;
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            pend_h    <= 1'b0;
            left_req  <= 1'b0;
            right_req <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + 1'b1;
            step_o    <= tick;
            mode      <= mode_next;
            phase     <= phase_next;
            // A grant consumes the latched press but re-captures a still-held switch.
            pend_l    <= grant ? l_s : (pend_l | l_s);
            pend_r    <= grant ? r_s : (pend_r | r_s);
            pend_h    <= grant ? h_s : (pend_h | h_s);
            left_req  <= left_req_next;
            right_req <= right_req_next;
            busy_o    <= (mode_next != MODE_IDLE);
        end
    end

`ifdef TBIRD_BRAKE_EN
    // Steady brake burn follows every cycle on whichever side is not flashing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_steady <= 1'b0;
            r_steady <= 1'b0;
        end else begin
            l_steady <= b_s & ~left_req_next;
            r_steady <= b_s & ~right_req_next;
        end
    end
`endif

    assign mode_o  = mode;
    assign phase_o = phase;

endmodule

// File: tb/tb_tbird_turn_scheduler.sv
// Directed testbench for tbird_turn_scheduler with TICK_DIV=4, SYNC_STAGES=2.
// Define TBIRD_BRAKE_EN to also exercise the brake steady outputs.
module tb_tbird_turn_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic left_sw = 1'b0, right_sw = 1'b0, hazard_sw = 1'b0;
    logic step_o, left_req, right_req, busy_o;
    logic [1:0] mode_o, phase_o;
`ifdef TBIRD_BRAKE_EN
    logic brake_sw = 1'b0;
    logic l_steady, r_steady;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [6:0] obs;
    assign obs = {mode_o, phase_o, left_req, right_req, busy_o};

    always #5 clk = ~clk;

    tbird_turn_scheduler #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .left_sw   (left_sw),
        .right_sw  (right_sw),
        .hazard_sw (hazard_sw),
`ifdef TBIRD_BRAKE_EN
        .brake_sw  (brake_sw),
        .l_steady  (l_steady),
        .r_steady  (r_steady),
`endif
        .step_o    (step_o),
        .left_req  (left_req),
        .right_req (right_req),
        .mode_o    (mode_o),
        .phase_o   (phase_o),
        .busy_o    (busy_o)
    );

    // Expected {mode, phase, left_req, right_req, busy} for a given mode/phase.
    function automatic logic [6:0] ev(input logic [1:0] m, input logic [1:0] p);
        return {m, p, (m == 2'd1 || m == 2'd3), (m == 2'd2 || m == 2'd3), (m != 2'd0)};
    endfunction

    task automatic applyStimulus(input logic l, input logic r, input logic h);
        left_sw   = l;
        right_sw  = r;
        hazard_sw = h;
    endtask

    task automatic do_reset(input logic l, input logic r, input logic h);
        reset = 1'b1;
        applyStimulus(l, r, h);
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Advance to the next step_o pulse (seen at a negedge), bounded.
    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!step_o && cyc < 20);
        if (!step_o) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL step_timeout: no step_o within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({obs, step_o} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {obs, step_o}, 8'h00);
        end
        reset = 1'b0;
        wait_step(cyc);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("[TB] FAIL first_step_latency: got %0d expected 4", cyc);
        end
        n_checks++;
        if (obs !== ev(2'd0, 2'd0)) begin
            n_fail++;
            $display("[TB] FAIL idle_no_request: got %b expected %b", obs, ev(2'd0, 2'd0));
        end
        wait_step(cyc);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("[TB] FAIL step_period: got %0d expected 4", cyc);
        end
    endtask

    task automatic test_left_hold();
        int cyc;
        logic [1:0] exp_m [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
        logic [1:0] exp_p [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        do_reset(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_step(cyc);
            n_checks++;
            if (obs !== ev(exp_m[i], exp_p[i])) begin
                n_fail++;
                $display("[TB] FAIL left_hold_step%0d: got %b expected %b", i, obs, ev(exp_m[i], exp_p[i]));
            end
            if (i > 0) begin
                n_checks++;
                if (cyc !== 4) begin
                    n_fail++;
                    $display("[TB] FAIL left_hold_spacing%0d: got %0d expected 4", i, cyc);
                end
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_pulse();
        int cyc;
        logic [1:0] exp_m [6] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        logic [1:0] exp_p [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        do_reset(1'b0, 1'b0, 1'b0);
        wait_step(cyc);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_step(cyc);
            n_checks++;
            if (obs !== ev(exp_m[i], exp_p[i])) begin
                n_fail++;
                $display("[TB] FAIL pulse_step%0d: got %b expected %b", i, obs, ev(exp_m[i], exp_p[i]));
            end
        end
    endtask

    task automatic test_hazard_lr();
        int cyc;
        do_reset(1'b0, 1'b0, 1'b0);
        wait_step(cyc);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_step(cyc);
        n_checks++;
        if (obs !== ev(2'd3, 2'd1)) begin
            n_fail++;
            $display("[TB] FAIL hazard_lr_grant: got %b expected %b", obs, ev(2'd3, 2'd1));
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) wait_step(cyc);
        wait_step(cyc);
        n_checks++;
        if (obs !== ev(2'd3, 2'd1)) begin
            n_fail++;
            $display("[TB] FAIL hazard_sw_grant: got %b expected %b", obs, ev(2'd3, 2'd1));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [1:0] exp_m [3] = '{2'd2, 2'd0, 2'd3};
        logic [1:0] exp_p [3] = '{2'd3, 2'd0, 2'd1};
        do_reset(1'b0, 1'b1, 1'b0);
        wait_step(cyc);
        n_checks++;
        if (obs !== ev(2'd2, 2'd1)) begin
            n_fail++;
            $display("[TB] FAIL right_grant: got %b expected %b", obs, ev(2'd2, 2'd1));
        end
        wait_step(cyc);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_step(cyc);
            n_checks++;
            if (obs !== ev(exp_m[i], exp_p[i])) begin
                n_fail++;
                $display("[TB] FAIL right_then_left_step%0d: got %b expected %b", i, obs, ev(exp_m[i], exp_p[i]));
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int cyc;
        do_reset(1'b1, 1'b0, 1'b0);
        wait_step(cyc);
        wait_step(cyc);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({obs, step_o} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL async_reset_outputs: got %b expected %b", {obs, step_o}, 8'h00);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_step(cyc);
            n_checks++;
            if (obs !== ev(2'd0, 2'd0)) begin
                n_fail++;
                $display("[TB] FAIL pending_lost_step%0d: got %b expected %b", i, obs, ev(2'd0, 2'd0));
            end
        end
    endtask

`ifdef TBIRD_BRAKE_EN
    task automatic test_brake();
        int cyc;
        brake_sw = 1'b1;
        do_reset(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_step(cyc);
            n_checks++;
            if ({l_steady, r_steady} !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL brake_left_step%0d: got %b expected 01", i, {l_steady, r_steady});
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b1);
        wait_step(cyc);
        for (int i = 0; i < 2; i++) begin
            wait_step(cyc);
            n_checks++;
            if ({l_steady, r_steady, mode_o} !== 4'b0011) begin
                n_fail++;
                $display("[TB] FAIL brake_hazard_step%0d: got %b expected 0011", i, {l_steady, r_steady, mode_o});
            end
        end
        brake_sw = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_left_hold();
        test_pulse();
        test_hazard_lr();
        test_back_to_back();
        test_async_reset();
`ifdef TBIRD_BRAKE_EN
        test_brake();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
